// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the MIPS general-purpose register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   REG_*                   : symbolic MIPS register indices (r0 is hardwired to zero)
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W_DEF-1:0] REG_AT   = 5'd1;
  localparam logic [ADDR_W_DEF-1:0] REG_V0   = 5'd2;
  localparam logic [ADDR_W_DEF-1:0] REG_A0   = 5'd4;
  localparam logic [ADDR_W_DEF-1:0] REG_T0   = 5'd8;
  localparam logic [ADDR_W_DEF-1:0] REG_S0   = 5'd16;
  localparam logic [ADDR_W_DEF-1:0] REG_GP   = 5'd28;
  localparam logic [ADDR_W_DEF-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W_DEF-1:0] REG_FP   = 5'd30;
  localparam logic [ADDR_W_DEF-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register, tracking writebacks in flight.
//   clk, rst      : clock, asynchronous active-high reset (clears all busy bits)
//   set_en/addr   : issue of an instruction that will write set_addr (sets busy)
//   clr_en/addr   : writeback to clr_addr (clears busy)
//   rd_addr       : flattened per-port lookup addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_busy       : registered busy bit of each looked-up register
// A set and a clear on the same register in one cycle leave it busy: the write
// retires an older producer while the newly issued one is still outstanding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;

  // Next busy vector: clear first, then set, so set wins on a shared address.
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr_en && (clr_addr != ADDR_ZERO)) begin
      busy_nxt_s[clr_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (set_en && (set_addr != ADDR_ZERO)) begin
      busy_nxt_s[set_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Per-port lookup of the registered busy bits.
  always_comb begin
    rd_busy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = busy_r[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: clocked MIPS register file, NUM_RD combinational read ports, one
// synchronous write port, r0 hardwired to zero, with a per-register busy scoreboard.
//   clk, rst             : clock, asynchronous active-high reset (clears data and busy)
//   regWrite/writeAddr/writeData : writeback port
//   rdAddr / rdData      : flattened read ports, port i at [i*W +: W]
//   rdBusy               : per-port pending-write flag for the addressed register
//   issueValid/issueAddr : decode issued an instruction that will write issueAddr
// Optional feature, macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeAddr,
  input  logic [DATA_W-1:0]        writeData,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdBusy,
  input  logic                     issueValid,
  input  logic [ADDR_W-1:0]        issueAddr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [NUM_RD-1:0] sb_busy_s;
  logic              wr_en_s;

  assign wr_en_s = regWrite && (writeAddr != ADDR_ZERO);

  // Data array: async clear, write on rising edge when enabled to a nonzero register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_r[k] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[writeAddr] <= writeData;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issueValid),
    .set_addr (issueAddr),
    .clr_en   (regWrite),
    .clr_addr (writeAddr),
    .rd_addr  (rdAddr),
    .rd_busy  (sb_busy_s)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = rdAddr[g*ADDR_W +: ADDR_W];

    // Read mux for one port; r0 reads zero regardless of contents or forwarding.
    always_comb begin
      data_s = {DATA_W{1'b0}};
      busy_s = sb_busy_s[g];
      if (addr_s == ADDR_ZERO) begin
        data_s = {DATA_W{1'b0}};
      end else begin
        data_s = regs_r[addr_s];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight write; gated by rst so reads stay zero during reset.
      // The register stays busy only if a new producer is issued on the same edge.
      if (!rst && wr_en_s && (writeAddr == addr_s)) begin
        data_s = writeData;
        busy_s = issueValid && (issueAddr == writeAddr);
      end else begin
        data_s = data_s;
      end
`endif
    end

    assign rdData[g*DATA_W +: DATA_W] = data_s;
    assign rdBusy[g]                  = busy_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, self-checking bench for regfile_mp (2 read ports).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic        issueValid;
  logic [4:0]  issueAddr;

  int errors;
  int checks;

  regfile_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regWrite   (regWrite),
    .writeAddr  (writeAddr),
    .writeData  (writeData),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .rdBusy     (rdBusy),
    .issueValid (issueValid),
    .issueAddr  (issueAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite   = 1'b0;
    writeAddr  = 5'd0;
    writeData  = 32'd0;
    issueValid = 1'b0;
    issueAddr  = 5'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    rdAddr = {5'd0, 5'd0};
    idle();
    step();
    step();
    rdAddr = {5'd8, 5'd5};
    #1;
    check_eq("reset_data0", rdData[31:0], 32'h0);
    check_eq("reset_data1", rdData[63:32], 32'h0);
    check_eq("reset_busy", {30'd0, rdBusy}, 32'h0);
    rst = 1'b0;
    step();

    // Write r5 and issue r7, then pulse reset mid-cycle.
    regWrite = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF;
    issueValid = 1'b1; issueAddr = 5'd7;
    step();
    idle();
    rdAddr = {5'd7, 5'd5};
    #1;
    check_eq("pre_rst_data", rdData[31:0], 32'hDEADBEEF);
    check_eq("pre_rst_busy", {30'd0, rdBusy}, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_data0", rdData[31:0], 32'h0);
    check_eq("async_rst_data1", rdData[63:32], 32'h0);
    check_eq("async_rst_busy", {30'd0, rdBusy}, 32'h0);
    // Write and issue presented on an edge while reset is high are dropped.
    regWrite = 1'b1; writeAddr = 5'd6; writeData = 32'h00000066;
    issueValid = 1'b1; issueAddr = 5'd6;
    step();
    idle();
    rst = 1'b0;
    rdAddr = {5'd6, 5'd6};
    #1;
    check_eq("rst_edge_wr_drop", rdData[31:0], 32'h0);
    check_eq("rst_edge_iss_drop", {30'd0, rdBusy}, 32'h0);
    step();

    // Basic write/read on both ports.
    regWrite = 1'b1; writeAddr = 5'd8; writeData = 32'h12345678;
    step();
    idle();
    rdAddr = {5'd8, 5'd8};
    #1;
    check_eq("r8_port0", rdData[31:0], 32'h12345678);
    check_eq("r8_port1", rdData[63:32], 32'h12345678);
    check_eq("r8_busy", {30'd0, rdBusy}, 32'h0);

    // Zero register ignores write and issue.
    regWrite = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF;
    issueValid = 1'b1; issueAddr = 5'd0;
    step();
    idle();
    rdAddr = {5'd0, 5'd0};
    #1;
    check_eq("r0_data", rdData[31:0], 32'h0);
    check_eq("r0_busy", {30'd0, rdBusy}, 32'h0);

    // Scoreboard set then clear on r31.
    issueValid = 1'b1; issueAddr = 5'd31;
    step();
    idle();
    rdAddr = {5'd31, 5'd8};
    #1;
    check_eq("r31_busy_set", {30'd0, rdBusy}, 32'h2);
    regWrite = 1'b1; writeAddr = 5'd31; writeData = 32'h00000400;
    step();
    idle();
    #1;
    check_eq("r31_busy_clr", {30'd0, rdBusy}, 32'h0);
    check_eq("r31_data", rdData[63:32], 32'h00000400);

    // Same-edge set and clear on r9: stays busy, data written.
    issueValid = 1'b1; issueAddr = 5'd9;
    step();
    regWrite = 1'b1; writeAddr = 5'd9; writeData = 32'h000000A5;
    issueValid = 1'b1; issueAddr = 5'd9;
    step();
    idle();
    rdAddr = {5'd9, 5'd9};
    #1;
    check_eq("r9_same_edge_busy", {30'd0, rdBusy}, 32'h3);
    check_eq("r9_same_edge_data", rdData[31:0], 32'h000000A5);

    // Different addresses on one edge: clear r9, set r10.
    regWrite = 1'b1; writeAddr = 5'd9; writeData = 32'h0000005A;
    issueValid = 1'b1; issueAddr = 5'd10;
    step();
    idle();
    rdAddr = {5'd10, 5'd9};
    #1;
    check_eq("diff_addr_busy", {30'd0, rdBusy}, 32'h2);
    check_eq("diff_addr_data", rdData[31:0], 32'h0000005A);

    // Write r3 with an old value, then overwrite it while reading it.
    regWrite = 1'b1; writeAddr = 5'd3; writeData = 32'h00000011;
    step();
    regWrite = 1'b1; writeAddr = 5'd3; writeData = 32'h00000077;
    rdAddr = {5'd0, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("bypass_same_cycle", rdData[31:0], 32'h00000077);
`else
    check_eq("no_bypass_old", rdData[31:0], 32'h00000011);
`endif
    check_eq("bypass_r0_zero", rdData[63:32], 32'h0);
    step();
    idle();
    #1;
    check_eq("r3_next_cycle", rdData[31:0], 32'h00000077);

    // Busy r10 being written while read: bypass drops busy, registered path keeps it.
    regWrite = 1'b1; writeAddr = 5'd10; writeData = 32'h0000AAAA;
    rdAddr = {5'd10, 5'd10};
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("bypass_busy_drop", {30'd0, rdBusy}, 32'h0);
`else
    check_eq("no_bypass_busy", {30'd0, rdBusy}, 32'h3);
`endif
    step();
    idle();
    #1;
    check_eq("r10_busy_after", {30'd0, rdBusy}, 32'h0);
    check_eq("r10_data_after", rdData[63:32], 32'h0000AAAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
